pe0_operand_feeder: RTL

Issue-side scheduler directly upstream of PE0 in the unified Kyber/Dilithium NTT datapath. Walks every butterfly of every layer of a 256-coefficient transform, generates coefficient-RAM and twiddle-ROM read addresses, and packs the returned data into the `PE0_a` / `w0` words PE0 expects, with a valid strobe. It also forwards the untouched top coefficient for the downstream add/sub path, so PE0 only ever sees operands already in its mode-specific format.

---
 rtl/pe0_operand_feeder_pkg.sv | 24 ++
 rtl/pe0_operand_feeder_addr_gen.sv | 28 ++
 rtl/pe0_operand_feeder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pe0_operand_feeder_pkg.sv
// pe0_operand_feeder_pkg: mode encodings, layer counts and FSM states shared by the PE0 operand feeder.
package pe0_operand_feeder_pkg;

    localparam logic [2:0] MODE_K2_NTT  = 3'b000;
    localparam logic [2:0] MODE_K2_INTT = 3'b010;
    localparam logic [2:0] MODE_D2_NTT  = 3'b100;
    localparam logic [2:0] MODE_D2_INTT = 3'b110;

    localparam int K_LAYERS     = 7;
    localparam int D_LAYERS     = 8;
    localparam int BF_PER_STAGE = 128;
    localparam int ADDR_W       = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic logic mode_ok(input logic [2:0] m);
        return m inside {MODE_K2_NTT, MODE_K2_INTT, MODE_D2_NTT, MODE_D2_INTT};
    endfunction

endpackage

// File: rtl/pe0_operand_feeder_addr_gen.sv
// pe0_addr_gen: combinational top/bottom coefficient and twiddle addresses for butterfly j of layer s.
module pe0_addr_gen
    import pe0_operand_feeder_pkg::*;
(
    input  logic              kd,
    input  logic              intt,
    input  logic [2:0]        s,
    input  logic [6:0]        j,
    output logic [ADDR_W-1:0] top,
    output logic [ADDR_W-1:0] bot,
    output logic [ADDR_W-1:0] tw
);
    logic [2:0]        lg;
    logic [ADDR_W-1:0] len, g, off;

    // Every mode's half-span is a power of two, so work with log2(len);
    // both twiddle formulas then collapse to 128/len + g.
    always_comb begin
        lg  = !intt ? 3'd7 - s : (kd ? s : s + 3'd1);
        len = 8'd1 << lg;
        g   = {1'b0, j} >> lg;
        off = {1'b0, j} & (len - 8'd1);
        top = ((g << 1) << lg) | off;
        bot = top + len;
        tw  = (8'd128 >> lg) + g;
    end

endmodule

// File: rtl/pe0_operand_feeder.sv
// pe0_operand_feeder: walks all NTT/INTT butterflies, issues RAM/ROM reads and packs PE0 operands.
// Optional inter-layer drain gap when PE0_FEED_STAGE_GAP_EN is defined.
module pe0_operand_feeder
    import pe0_operand_feeder_pkg::*;
#(
    parameter int data_width = 24,
    parameter int GAP_CYCLES = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sel_0,
    input  logic                  sel_1,
    input  logic                  KD_mode,
    input  logic                  hold,
    output logic                  coef_ren,
    output logic [ADDR_W-1:0]     coef_raddr_top,
    output logic [ADDR_W-1:0]     coef_raddr_bot,
    input  logic [data_width-1:0] coef_rdata_top,
    input  logic [data_width-1:0] coef_rdata_bot,
    output logic                  tw_ren,
    output logic [ADDR_W-1:0]     tw_raddr,
    input  logic [data_width-1:0] tw_rdata,
    output logic [data_width-1:0] PE0_a,
    output logic [data_width-1:0] w0,
    output logic [data_width-1:0] top_out,
    output logic                  feed_valid,
    output logic [2:0]            stage,
    output logic                  busy,
    output logic                  done,
    output logic                  mode_err
);
    localparam int H = data_width / 2;

    logic [2:0]        state, s;
    logic [6:0]        j;
    logic              kd, intt, drain, v1, issue, last_layer;
    logic [ADDR_W-1:0] a_top, a_bot, a_tw;

`ifdef PE0_FEED_STAGE_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    logic [GAP_W-1:0] gap_cnt;
`else
    localparam int unused_gap = GAP_CYCLES;
`endif

    pe0_addr_gen u_addr_gen (
        .kd   (kd),
        .intt (intt),
        .s    (s),
        .j    (j),
        .top  (a_top),
        .bot  (a_bot),
        .tw   (a_tw)
    );

    assign issue          = state == ST_RUN && !hold;
    assign last_layer     = s == (kd ? 3'(D_LAYERS - 1) : 3'(K_LAYERS - 1));
    assign coef_ren       = issue;
    assign tw_ren         = issue;
    assign coef_raddr_top = issue ? a_top : '0;
    assign coef_raddr_bot = issue ? a_bot : '0;
    assign tw_raddr       = issue ? a_tw : '0;
    assign stage          = s;
    assign busy           = state != ST_IDLE;
    assign done           = state == ST_DONE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            s          <= '0;
            j          <= '0;
            kd         <= 1'b0;
            intt       <= 1'b0;
            drain      <= 1'b0;
            v1         <= 1'b0;
            feed_valid <= 1'b0;
            mode_err   <= 1'b0;
            PE0_a      <= '0;
            w0         <= '0;
            top_out    <= '0;
`ifdef PE0_FEED_STAGE_GAP_EN
            gap_cnt    <= '0;
`endif
        end else begin
            mode_err   <= state == ST_IDLE && start && !mode_ok({KD_mode, sel_1, sel_0});
            v1         <= issue;
            feed_valid <= v1;
            // Read data arrives one cycle after the issue; pack it into PE0's mode format.
            if (v1) begin
                PE0_a   <= kd ? coef_rdata_bot : {coef_rdata_top[H-1:0], coef_rdata_bot[H-1:0]};
                w0      <= kd ? tw_rdata : {H'(1), tw_rdata[H-1:0]};
                top_out <= kd ? coef_rdata_top : '0;
            end
            case (state)
                ST_IDLE: if (start && mode_ok({KD_mode, sel_1, sel_0})) begin
                    state <= ST_RUN;
                    kd    <= KD_mode;
                    intt  <= sel_1;
                    s     <= '0;
                    j     <= '0;
                end
                ST_RUN: if (issue) begin
                    j <= j + 7'd1;
                    if (j == 7'(BF_PER_STAGE - 1)) begin
                        if (last_layer) begin
                            state <= ST_DRAIN;
                            drain <= 1'b0;
                        end
`ifdef PE0_FEED_STAGE_GAP_EN
                        else begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                        end
`else
                        else s <= s + 3'd1;
`endif
                    end
                end
`ifdef PE0_FEED_STAGE_GAP_EN
                ST_GAP: if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state <= ST_RUN;
                    s     <= s + 3'd1;
                end else gap_cnt <= gap_cnt + GAP_W'(1);
`endif
                ST_DRAIN: begin
                    drain <= 1'b1;
                    if (drain) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
